// File: rtl/ines_loader_if.sv
// ines_loader_if: byte-wide memory write port between the iNES loader and memory.
interface ines_loader_if;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_write;
  logic        mem_ack;
  modport master (output mem_addr, output mem_din, output mem_write, input mem_ack);
  modport slave  (input mem_addr, input mem_din, input mem_write, output mem_ack);
endinterface

// File: rtl/ines_loader.sv
// ines_loader: parses an iNES byte stream and writes PRG to address 0 and CHR to CHR_BASE.
module ines_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [21:0] CHR_BASE   = 22'h200000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           indata,
  input  logic                 indata_valid,
  ines_loader_if.master        mem,
  output logic [31:0]          mapper_flags,
  output logic                 done,
  output logic                 error
);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [31:0] MAGIC = 32'h1A53454E;
  typedef enum logic [2:0] {HEADER, TRAINER, PRG, CHR, DONE, ERROR} state_t;
  state_t      state, nxt;
  logic [7:0]  fifo [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [21:0] off, off_nxt;
  logic [7:0]  head;
  logic        empty, full, active, push, pop, prg_last, chr_last;
  assign head          = fifo[rd_ptr[AW-1:0]];
  assign empty         = wr_ptr == rd_ptr;
  assign full          = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
  assign active        = state inside {HEADER, TRAINER, PRG, CHR};
  assign push          = indata_valid && !full && active;
  assign mem.mem_write = (state == PRG || state == CHR) && !empty;
  assign mem.mem_din   = mem.mem_write ? head : 8'd0;
  assign mem.mem_addr  = state == CHR ? CHR_BASE + off : off;
  // Header and trainer drain freely; payload bytes leave only when memory acknowledges them.
  assign pop           = (state == HEADER || state == TRAINER) ? !empty : mem.mem_write && mem.mem_ack;
  assign prg_last      = off == (22'(mapper_flags[7:0]) << 14) - 22'd1;
  assign chr_last      = off == (22'(mapper_flags[15:8]) << 13) - 22'd1;
  assign done          = state == DONE;
  assign error         = state == ERROR;
  always_comb begin
    nxt     = state;
    off_nxt = pop ? off + 22'd1 : off;
    if (pop) begin
      if (state == HEADER && off < 22'd4 && head != MAGIC[{off[1:0], 3'b000} +: 8]) nxt = ERROR;
      else if (state == HEADER && off == 22'd15) begin
        off_nxt = '0;
        nxt     = (mapper_flags[7:0] == 8'd0 || mapper_flags[7:0] > 8'd128) ? ERROR :
                  mapper_flags[18] ? TRAINER : PRG;
      end else if (state == TRAINER && off == 22'd511) begin
        off_nxt = '0;
        nxt     = PRG;
      end else if (state == PRG && prg_last) begin
        off_nxt = '0;
        nxt     = mapper_flags[15:8] == 8'd0 ? DONE : CHR;
      end else if (state == CHR && chr_last) begin
        off_nxt = '0;
        nxt     = DONE;
      end
    end
    if (indata_valid && full && active) nxt = ERROR;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= HEADER;
      off          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mapper_flags <= '0;
    end else begin
      state  <= nxt;
      off    <= off_nxt;
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      if (state == HEADER && pop && off >= 22'd4 && off < 22'd8)
        mapper_flags[{off[1:0], 3'b000} +: 8] <= head;
    end
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr[AW-1:0]] <= indata;
endmodule

// File: tb/tb_ines_loader.sv
// tb_ines_loader: directed scenarios for the iNES loader with a scripted memory responder.
module tb_ines_loader;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  indata = 8'd0;
  logic        indata_valid = 1'b0;
  logic [31:0] mapper_flags;
  logic        done, error;
  ines_loader_if bus();
  ines_loader dut (
    .clk(clk), .resetn(resetn), .indata(indata), .indata_valid(indata_valid),
    .mem(bus), .mapper_flags(mapper_flags), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  int pass_cnt = 0;
  int total_cnt = 0;
  bit ack_en = 0, ack_lat = 0, seen = 0, stray = 0, write_seen = 0;
  logic [21:0] addr_q [$];
  logic [7:0]  data_q [$];
  logic [7:0]  hdr [16];
  // ack_lat=0 acks in the request cycle, ack_lat=1 acks one cycle after the request
  always @(negedge clk) begin
    if (!ack_en) begin
      bus.mem_ack = 1'b0;
      seen = 0;
    end else if (!ack_lat) bus.mem_ack = bus.mem_write;
    else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      seen = bus.mem_write;
    end else if (bus.mem_write) begin
      bus.mem_ack = seen;
      seen = !seen;
    end else seen = 0;
    if (bus.mem_write) write_seen = 1;
    if (bus.mem_ack && bus.mem_write) begin
      addr_q.push_back(bus.mem_addr);
      data_q.push_back(bus.mem_din);
    end
    if (stray) bus.mem_ack = 1'b1;
  end
  function automatic logic [7:0] pat(input int k);
    return 8'(k * 13 + (k >> 8) + 5);
  endfunction
  task automatic send_byte(input logic [7:0] b, input int gap);
    indata = b;
    indata_valid = 1'b1;
    @(negedge clk);
    indata_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask
  task automatic send_stream(input int npay, input int gap);
    for (int i = 0; i < 16; i++) send_byte(hdr[i], gap);
    for (int k = 0; k < npay; k++) send_byte(pat(k), gap);
  endtask
  task automatic set_hdr(input logic [7:0] prg, input logic [7:0] chr, input logic [7:0] f6, input logic [7:0] m2);
    hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = m2; hdr[3] = 8'h1A;
    hdr[4] = prg; hdr[5] = chr; hdr[6] = f6;
    for (int i = 7; i < 16; i++) hdr[i] = 8'h00;
  endtask
  task automatic do_reset;
    resetn = 1'b0;
    ack_en = 0;
    indata_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    addr_q.delete();
    data_q.delete();
    write_seen = 0;
  endtask
  task automatic wait_done(input int max);
    for (int i = 0; i < max && !done; i++) @(negedge clk);
  endtask
  task automatic test_reset;
    resetn = 1'b0;
    ack_en = 0;
    indata = 8'hAB;
    indata_valid = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", bus.mem_write); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 22'd0) $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_din !== 8'd0) $display("FAIL rst_mem_din: got %h want 0", bus.mem_din); else pass_cnt++;
    total_cnt++; if (mapper_flags !== 32'd0) $display("FAIL rst_flags: got %h want 0", mapper_flags); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else pass_cnt++;
    indata_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    total_cnt++; if (error !== 1'b0) $display("FAIL rst_release_error: got %b want 0", error); else pass_cnt++;
  endtask
  task automatic test_full_load;
    int bad_prg, bad_chr, n;
    logic [21:0] ea;
    do_reset();
    ack_en = 1;
    ack_lat = 1;
    set_hdr(8'd1, 8'd1, 8'h00, 8'h53);
    send_stream(24576, 2);
    wait_done(100);
    total_cnt++; if (done !== 1'b1) $display("FAIL full_done: got %b want 1", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL full_error: got %b want 0", error); else pass_cnt++;
    total_cnt++; if (mapper_flags !== 32'h00000101) $display("FAIL full_flags: got %h want 00000101", mapper_flags); else pass_cnt++;
    total_cnt++; if (addr_q.size() !== 24576) $display("FAIL full_count: got %0d want 24576", addr_q.size()); else pass_cnt++;
    bad_prg = 0;
    bad_chr = 0;
    for (int j = 0; j < addr_q.size(); j++) begin
      ea = j < 16384 ? 22'(j) : 22'(32'h200000 + j - 16384);
      if (addr_q[j] !== ea || data_q[j] !== pat(j)) begin
        if (j < 16384) bad_prg++; else bad_chr++;
      end
    end
    total_cnt++; if (bad_prg !== 0) $display("FAIL full_prg_writes: got %0d bad want 0", bad_prg); else pass_cnt++;
    total_cnt++; if (bad_chr !== 0) $display("FAIL full_chr_writes: got %0d bad want 0", bad_chr); else pass_cnt++;
    n = addr_q.size();
    for (int i = 0; i < 8; i++) send_byte(8'h55, 1);
    repeat (3) @(negedge clk);
    total_cnt++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL done_discard_state: got done=%b error=%b want 1 0", done, error); else pass_cnt++;
    total_cnt++; if (addr_q.size() !== n) $display("FAIL done_discard_writes: got %0d want %0d", addr_q.size(), n); else pass_cnt++;
  endtask
  task automatic test_bad_magic;
    do_reset();
    ack_en = 1;
    ack_lat = 0;
    set_hdr(8'd1, 8'd0, 8'h00, 8'h54);
    for (int i = 0; i < 3; i++) send_byte(hdr[i], 1);
    total_cnt++; if (error !== 1'b0) $display("FAIL magic_before_byte2: got %b want 0", error); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (error !== 1'b1) $display("FAIL magic_after_byte2: got %b want 1", error); else pass_cnt++;
    for (int i = 3; i < 16; i++) send_byte(hdr[i], 1);
    for (int k = 0; k < 20; k++) send_byte(pat(k), 1);
    repeat (3) @(negedge clk);
    total_cnt++; if (error !== 1'b1) $display("FAIL magic_sticky: got %b want 1", error); else pass_cnt++;
    total_cnt++; if (write_seen !== 1'b0) $display("FAIL magic_no_write: got %b want 0", write_seen); else pass_cnt++;
  endtask
  task automatic test_prg_limits;
    do_reset();
    set_hdr(8'h81, 8'd1, 8'h00, 8'h53);
    for (int i = 0; i < 16; i++) send_byte(hdr[i], 1);
    total_cnt++; if (error !== 1'b0) $display("FAIL prg81_before_byte15: got %b want 0", error); else pass_cnt++;
    total_cnt++; if (mapper_flags !== 32'h00000181) $display("FAIL prg81_flags: got %h want 00000181", mapper_flags); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (error !== 1'b1) $display("FAIL prg81_after_byte15: got %b want 1", error); else pass_cnt++;
    do_reset();
    set_hdr(8'h80, 8'd0, 8'h00, 8'h53);
    for (int i = 0; i < 16; i++) send_byte(hdr[i], 1);
    repeat (2) @(negedge clk);
    total_cnt++; if (error !== 1'b0) $display("FAIL prg80_accepted: got %b want 0", error); else pass_cnt++;
    do_reset();
    set_hdr(8'h00, 8'd1, 8'h00, 8'h53);
    for (int i = 0; i < 16; i++) send_byte(hdr[i], 1);
    repeat (2) @(negedge clk);
    total_cnt++; if (error !== 1'b1) $display("FAIL prg0_rejected: got %b want 1", error); else pass_cnt++;
  endtask
  task automatic test_overflow;
    do_reset();
    set_hdr(8'd1, 8'd0, 8'h00, 8'h53);
    send_stream(4, 1);
    total_cnt++; if (error !== 1'b0) $display("FAIL ovf_full_no_error: got %b want 0", error); else pass_cnt++;
    total_cnt++; if (bus.mem_write !== 1'b1) $display("FAIL ovf_write_pending: got %b want 1", bus.mem_write); else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++; if (bus.mem_addr !== 22'd0 || bus.mem_din !== pat(0)) $display("FAIL ovf_stable: got %h/%h want 000000/%h", bus.mem_addr, bus.mem_din, pat(0)); else pass_cnt++;
    send_byte(pat(4), 1);
    total_cnt++; if (error !== 1'b1) $display("FAIL ovf_error: got %b want 1", error); else pass_cnt++;
    total_cnt++; if (bus.mem_write !== 1'b0) $display("FAIL ovf_write_dropped: got %b want 0", bus.mem_write); else pass_cnt++;
  endtask
  task automatic test_reset_mid_write_then_trainer;
    int bad;
    do_reset();
    set_hdr(8'd1, 8'd1, 8'h00, 8'h53);
    send_stream(3, 1);
    @(negedge clk);
    total_cnt++; if (bus.mem_write !== 1'b1) $display("FAIL mid_write_pending: got %b want 1", bus.mem_write); else pass_cnt++;
    resetn = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.mem_write !== 1'b0) $display("FAIL mid_reset_drop: got %b want 0", bus.mem_write); else pass_cnt++;
    total_cnt++; if (mapper_flags !== 32'd0) $display("FAIL mid_reset_flags: got %h want 0", mapper_flags); else pass_cnt++;
    resetn = 1'b1;
    stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (2) @(negedge clk);
    addr_q.delete();
    data_q.delete();
    ack_en = 1;
    ack_lat = 0;
    set_hdr(8'd1, 8'd0, 8'h04, 8'h53);
    send_stream(512 + 16384, 1);
    wait_done(50);
    total_cnt++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL trn_done: got done=%b error=%b want 1 0", done, error); else pass_cnt++;
    total_cnt++; if (mapper_flags !== 32'h00040001) $display("FAIL trn_flags: got %h want 00040001", mapper_flags); else pass_cnt++;
    total_cnt++; if (addr_q.size() !== 16384) $display("FAIL trn_count: got %0d want 16384", addr_q.size()); else pass_cnt++;
    total_cnt++; if ((addr_q.size() > 0 ? addr_q[0] : 22'bx) !== 22'd0) $display("FAIL trn_first_addr: got %h want 0", addr_q.size() > 0 ? addr_q[0] : 22'bx); else pass_cnt++;
    total_cnt++; if ((data_q.size() > 0 ? data_q[0] : 8'bx) !== pat(512)) $display("FAIL trn_first_data: got %h want %h", data_q.size() > 0 ? data_q[0] : 8'bx, pat(512)); else pass_cnt++;
    bad = 0;
    for (int j = 0; j < addr_q.size(); j++)
      if (addr_q[j] !== 22'(j) || data_q[j] !== pat(512 + j)) bad++;
    total_cnt++; if (bad !== 0) $display("FAIL trn_writes: got %0d bad want 0", bad); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_full_load();
    test_bad_magic();
    test_prg_limits();
    test_overflow();
    test_reset_mid_write_then_trainer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ines_loader.md
INES_LOADER -- requirements
Module: ines_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input buffer depth in bytes (power of two, >=2).
REQ-002 Parameter CHR_BASE, default 22'h200000, memory byte address of CHR byte 0.
REQ-003 clk  input  1  clock.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 indata  input  8  ROM file byte stream from the SD loader.
REQ-006 indata_valid  input  1  one-cycle pulse; indata is valid; no backpressure exists.
REQ-007 mem_addr  output  22  byte address of the pending memory write.
REQ-008 mem_din  output  8  data of the pending memory write.
REQ-009 mem_write  output  1  write request, level, held until acknowledged.
REQ-010 mem_ack  input  1  one-cycle pulse; the pending write is complete.
REQ-011 mapper_flags  output  32  {flags7, flags6, chr_units, prg_units} from the header.
REQ-012 done  output  1  ROM fully written to memory; sticky until reset.
REQ-013 error  output  1  load aborted; sticky until reset.

Function
REQ-014 Every accepted byte (indata_valid=1, FIFO not full) SHALL be pushed into a FIFO_DEPTH-entry FIFO; push and pop in the same cycle SHALL both occur.
REQ-015 indata_valid=1 while the FIFO is full SHALL drop the byte and enter ERROR.
REQ-016 States: HEADER, TRAINER, PRG, CHR, DONE, ERROR; reset state HEADER.
REQ-017 HEADER: pop one byte per cycle, 16 bytes total; bytes 0-3 SHALL equal 4E 45 53 1A, otherwise ERROR on the first mismatching byte.
REQ-018 Header byte 4 -> prg_units, 5 -> chr_units, 6 -> flags6, 7 -> flags7; bytes 8-15 are discarded.
REQ-019 After byte 15: prg_units==0 or prg_units>128 -> ERROR; else flags6[2]=1 -> TRAINER, else PRG.
REQ-020 TRAINER: pop and discard exactly 512 bytes, one per cycle, then PRG.
REQ-021 PRG: for each byte, mem_addr = byte offset (0-based, 22 bits), mem_din = byte; total prg_units*16384 bytes.
REQ-022 CHR: mem_addr = CHR_BASE + offset, truncated to 22 bits; total chr_units*8192 bytes.
REQ-023 After the last PRG byte: chr_units==0 -> DONE, else CHR; after the last CHR byte -> DONE.
REQ-024 In PRG/CHR, mem_write SHALL assert the cycle after the FIFO becomes non-empty; mem_addr/mem_din SHALL remain stable while mem_write=1.
REQ-025 On mem_ack with mem_write=1, the FIFO entry SHALL pop and the offset SHALL increment; the next write MAY assert in the following cycle.
REQ-026 mem_ack while mem_write=0 SHALL be ignored.
REQ-027 Byte latency: a byte accepted in cycle N into an empty FIFO SHALL appear on mem_write in cycle N+1 at the earliest.
REQ-028 DONE: done=1; further input bytes are accepted and discarded; overflow is not checked.
REQ-029 ERROR: error=1, mem_write=0; all input is ignored.
REQ-030 mapper_flags SHALL update as each header byte is consumed and hold its value afterwards.
REQ-031 Offset counters SHALL be wide enough for 2 MiB (22 bits) without wrap.

Reset
REQ-032 resetn=0 at a clk edge SHALL produce the state HEADER, an empty FIFO, zeroed offset counters, mem_write=0, mem_addr=0, mem_din=0, mapper_flags=0, done=0 and error=0.
REQ-033 Reset mid-write SHALL drop the pending request immediately, with no completion required; a mem_ack arriving after reset SHALL be ignored.

Verification
REQ-034 Header 4E 45 53 1A 01 01 00 00 + 8 zeros, 16384 PRG + 8192 CHR bytes, mem_ack 1 cycle after each request -> PRG written at 0x000000-0x003FFF, CHR at 0x200000-0x201FFF, mapper_flags=0x00000101, done=1.
REQ-035 Header with byte 2 = 0x54 -> error=1 after byte 2, no mem_write ever asserts.
REQ-036 flags6=0x04, prg=1, chr=0 -> the first 512 post-header bytes are never written, the first mem_din equals byte 528 of the file, done follows the final PRG write.
REQ-037 mem_ack withheld for 10 cycles while 5 bytes arrive back-to-back after the FIFO holds 0 -> the 5th byte sets error=1 (FIFO_DEPTH=4).
REQ-038 prg_units=0x81 -> error=1 after header byte 15.
REQ-039 resetn pulsed low during PRG with mem_write=1, then a complete valid file -> the full load completes from address 0, and done=1.
